// File: rtl/branch_resolve_bht_if.sv
// rtl/branch_resolve_bht_if.sv - fetch prediction, EX branch and resolution signals of the branch unit
interface branch_resolve_bht_if #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8
);
  logic              pred_taken;
  logic [DATA_W-1:0] fetch_pc;
  logic              ex_valid;
  logic              ex_flush;
  logic [1:0]        branchOp;
  logic [DATA_W-1:0] Rs;
  logic [IMM_W-1:0]  Imm;
  logic [DATA_W-1:0] PC_plus_two;
  logic              ex_pred_taken;
  logic              res_valid;
  logic              res_taken;
  logic [DATA_W-1:0] branchTarget;
  logic              mispredict;
  logic [DATA_W-1:0] redirect_pc;
  logic              err;

  modport master (
    output fetch_pc, ex_valid, ex_flush, branchOp, Rs, Imm, PC_plus_two, ex_pred_taken,
    input  pred_taken, res_valid, res_taken, branchTarget, mispredict, redirect_pc, err
  );

  modport slave (
    input  fetch_pc, ex_valid, ex_flush, branchOp, Rs, Imm, PC_plus_two, ex_pred_taken,
    output pred_taken, res_valid, res_taken, branchTarget, mispredict, redirect_pc, err
  );
endinterface

// File: rtl/branch_resolve_bht.sv
// rtl/branch_resolve_bht.sv - EX branch resolution with a saturating-counter branch history table
module branch_resolve_bht #(
  parameter int DATA_W  = 16,
  parameter int IMM_W   = 8,
  parameter int BHT_IDX = 4,
  parameter int CTR_W   = 2
) (
  input logic                 clk,
  input logic                 rst,
  branch_resolve_bht_if.slave bus
);
  localparam int ENTRIES = 1 << BHT_IDX;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_MAX >> 1;

  logic [CTR_W-1:0]   bht [ENTRIES];
  logic [BHT_IDX-1:0] fetch_idx;
  logic [BHT_IDX-1:0] train_idx;
  logic [CTR_W-1:0]   ctr_cur;
  logic [CTR_W-1:0]   ctr_next;
  logic [DATA_W-1:0]  imm_ext;
  logic [DATA_W:0]    sum;
  logic               cond;
  logic               wrap;
  logic               fire;

  logic              res_valid_q;
  logic              res_taken_q;
  logic [DATA_W-1:0] target_q;
  logic              mispredict_q;
  logic [DATA_W-1:0] redirect_q;
  logic              err_q;

  // Index by halfword address; bit 0 and high PC bits alias deliberately.
  assign fetch_idx = BHT_IDX'(bus.fetch_pc >> 1);
  assign train_idx = BHT_IDX'((bus.PC_plus_two - DATA_W'(2)) >> 1);
  assign bus.pred_taken = bht[fetch_idx][CTR_W-1];

  assign fire    = bus.ex_valid & ~bus.ex_flush;
  assign imm_ext = {{(DATA_W-IMM_W){bus.Imm[IMM_W-1]}}, bus.Imm};
  assign sum     = {1'b0, bus.PC_plus_two} + {1'b0, imm_ext};
  // Carry out means overflow for a forward jump, no carry means underflow for a backward one.
  assign wrap    = bus.Imm[IMM_W-1] ? ~sum[DATA_W] : sum[DATA_W];

  always_comb begin
    cond = 1'b0;
    case (bus.branchOp)
      2'b00: cond = (bus.Rs == '0);
      2'b01: cond = (bus.Rs != '0);
      2'b10: cond = bus.Rs[DATA_W-1];
      2'b11: cond = ~bus.Rs[DATA_W-1];
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    ctr_cur  = bht[train_idx];
    ctr_next = ctr_cur;
    if (cond && ctr_cur != CTR_MAX)
      ctr_next = ctr_cur + CTR_W'(1);
    else if (!cond && ctr_cur != '0)
      ctr_next = ctr_cur - CTR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        bht[i] <= CTR_INIT;
    end else if (fire) begin
      bht[train_idx] <= ctr_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q  <= 1'b0;
      res_taken_q  <= 1'b0;
      target_q     <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      res_valid_q  <= fire;
      mispredict_q <= fire & (cond != bus.ex_pred_taken);
      err_q        <= fire & cond & wrap;
      if (fire) begin
        res_taken_q <= cond;
        target_q    <= sum[DATA_W-1:0];
        redirect_q  <= cond ? sum[DATA_W-1:0] : bus.PC_plus_two;
      end
    end
  end

  assign bus.res_valid    = res_valid_q;
  assign bus.res_taken    = res_taken_q;
  assign bus.branchTarget = target_q;
  assign bus.mispredict   = mispredict_q;
  assign bus.redirect_pc  = redirect_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb/tb_branch_resolve_bht.sv - directed and randomized checks of branch_resolve_bht against a reference model
module tb_branch_resolve_bht;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  int ctr [16];
  int m_rv, m_rt, m_tgt, m_mp, m_rpc, m_err;

  branch_resolve_bht_if #(.DATA_W(16), .IMM_W(8)) bus ();

  branch_resolve_bht #(.DATA_W(16), .IMM_W(8), .BHT_IDX(4), .CTR_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_cond(input int op, input int rs);
    case (op)
      0: return (rs == 0) ? 1 : 0;
      1: return (rs != 0) ? 1 : 0;
      2: return (rs >= 32768) ? 1 : 0;
      default: return (rs < 32768) ? 1 : 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ctr[i] = 1;
    m_rv = 0; m_rt = 0; m_tgt = 0; m_mp = 0; m_rpc = 0; m_err = 0;
  endtask

  task automatic check_res(input string tag);
    chk({tag, ".res_valid"},    32'(bus.res_valid),    32'(m_rv));
    chk({tag, ".res_taken"},    32'(bus.res_taken),    32'(m_rt));
    chk({tag, ".branchTarget"}, 32'(bus.branchTarget), 32'(m_tgt));
    chk({tag, ".mispredict"},   32'(bus.mispredict),   32'(m_mp));
    chk({tag, ".redirect_pc"},  32'(bus.redirect_pc),  32'(m_rpc));
    chk({tag, ".err"},          32'(bus.err),          32'(m_err));
  endtask

  function automatic int pred_of(input int pc);
    return (ctr[(pc >> 1) & 15] >= 2) ? 1 : 0;
  endfunction

  // One EX cycle: drive at negedge, check the prediction before the edge, results after it.
  task automatic step(input string tag, input int v, input int fl, input int op, input int rs,
                      input int imm, input int pc2, input int ept, input int fpc);
    int c, simm, s, idx;
    @(negedge clk);
    bus.ex_valid      = v[0];
    bus.ex_flush      = fl[0];
    bus.branchOp      = op[1:0];
    bus.Rs            = rs[15:0];
    bus.Imm           = imm[7:0];
    bus.PC_plus_two   = pc2[15:0];
    bus.ex_pred_taken = ept[0];
    bus.fetch_pc      = fpc[15:0];
    #1;
    chk({tag, ".pred_taken"}, 32'(bus.pred_taken), 32'(pred_of(fpc)));
    @(posedge clk);
    if (v != 0 && fl == 0) begin
      c    = model_cond(op, rs);
      simm = (imm >= 128) ? imm - 256 : imm;
      s    = pc2 + simm;
      m_rv  = 1;
      m_rt  = c;
      m_tgt = s & 16'hFFFF;
      m_mp  = (c != ept) ? 1 : 0;
      m_rpc = c ? m_tgt : pc2;
      m_err = (c != 0 && (s < 0 || s > 65535)) ? 1 : 0;
      idx = (((pc2 - 2) & 16'hFFFF) >> 1) & 15;
      if (c != 0) ctr[idx] = (ctr[idx] < 3) ? ctr[idx] + 1 : 3;
      else        ctr[idx] = (ctr[idx] > 0) ? ctr[idx] - 1 : 0;
    end else begin
      m_rv = 0; m_mp = 0; m_err = 0;
    end
    #1;
    check_res(tag);
  endtask

  initial begin
    int v, fl, op, rs, imm, pc2, ept, fpc;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_flush = 1'b0; bus.branchOp = 2'b00;
    bus.Rs = '0; bus.Imm = '0; bus.PC_plus_two = '0; bus.ex_pred_taken = 1'b0;
    bus.fetch_pc = 16'h0010;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pred_taken", 32'(bus.pred_taken), 32'd0);
    check_res("reset");
    @(negedge clk);
    rst = 1'b0;

    // Taken BEQZ predicted not-taken
    step("t2", 1, 0, 0, 0, 8'h04, 16'h0012, 0, 16'h0040);
    chk("t2.target_lit", 32'(bus.branchTarget), 32'h0016);
    chk("t2.redirect_lit", 32'(bus.redirect_pc), 32'h0016);

    // Counter walk for PC 0x0010; t2 already moved it to 10
    step("t3a", 1, 0, 0, 0, 8'h04, 16'h0012, 1, 16'h0010);
    step("t3b", 1, 0, 1, 0, 8'h04, 16'h0012, 1, 16'h0010);
    step("t3c", 1, 0, 1, 0, 8'h04, 16'h0012, 1, 16'h0010);
    step("t3d", 1, 0, 1, 0, 8'h04, 16'h0012, 0, 16'h0010);
    step("t3e", 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0010);
    chk("t3.pred_lit", 32'(bus.pred_taken), 32'd0);

    // BGEZ on negative Rs, predicted taken
    step("t4", 1, 0, 3, 16'h8000, 8'h10, 16'h0100, 1, 16'h0000);
    chk("t4.redirect_lit", 32'(bus.redirect_pc), 32'h0100);

    // Target wrap: taken raises err, not-taken does not
    step("t5a", 1, 0, 1, 1, 8'h7F, 16'hFFF0, 0, 16'h0000);
    chk("t5a.target_lit", 32'(bus.branchTarget), 32'h006F);
    chk("t5a.err_lit", 32'(bus.err), 32'd1);
    step("t5b", 1, 0, 0, 1, 8'h7F, 16'hFFF0, 0, 16'h0000);
    chk("t5b.err_lit", 32'(bus.err), 32'd0);
    step("t5c", 1, 0, 1, 1, 8'h80, 16'h0004, 1, 16'h0000);
    step("t5d", 0, 0, 1, 1, 8'h80, 16'h0004, 1, 16'h0000);

    // Flushed branch is dropped; its entry stays untouched
    step("t6a", 1, 1, 0, 0, 8'h02, 16'h0022, 0, 16'h0020);
    step("t6b", 1, 1, 0, 0, 8'h02, 16'h0022, 0, 16'h0020);
    step("t6c", 1, 0, 0, 0, 8'h02, 16'h0022, 0, 16'h0020);
    step("t6d", 1, 0, 0, 0, 8'h02, 16'h0022, 0, 16'h0020);
    step("t6e", 1, 0, 0, 0, 8'h02, 16'h0022, 1, 16'h0020);

    // Reset in the middle of a burst clears outputs and history at once
    rst = 1'b1;
    #1;
    model_reset();
    check_res("t6rst");
    chk("t6rst.pred_taken", 32'(bus.pred_taken), 32'd0);
    @(negedge clk);
    bus.ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step("t6post", 1, 0, 0, 0, 8'h02, 16'h0022, 0, 16'h0020);

    for (int n = 0; n < 300; n++) begin
      v   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      fl  = ($urandom_range(0, 7) == 0) ? 1 : 0;
      op  = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: rs = 0;
        1: rs = 16'h8000 | $urandom_range(0, 32767);
        default: rs = $urandom_range(0, 65535);
      endcase
      imm = $urandom_range(0, 255);
      pc2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : 2 * $urandom_range(1, 6);
      ept = $urandom_range(0, 1);
      fpc = ($urandom_range(0, 1) == 0) ? ((pc2 - 2) & 16'hFFFF) : $urandom_range(0, 65535);
      step("rnd", v, fl, op, rs, imm, pc2, ept, fpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
